// File: rtl/acc_bias_128.sv
// rtl/acc_bias_128.sv - per-column tile accumulator with first-beat bias add and valid/ready result register
// Optional build macro ACC_SAT_EN: clamp each addition to the AB_BW signed range and report a sticky o_acc_sat.
module acc_bias_128 #(
    parameter int COLS   = 5,
    parameter int PS_BW  = 16,
    parameter int BI_BW  = 16,
    parameter int AB_BW  = 25,
    parameter int CNT_BW = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_bias_we,
    input  logic [BI_BW*COLS-1:0]   i_bias_data,
    input  logic                    i_ps_valid,
    input  logic                    i_ps_last,
    input  logic [PS_BW*COLS-1:0]   i_ps_data,
    output logic                    o_ps_ready,
    output logic                    o_acc_valid,
    input  logic                    i_acc_ready,
    output logic [AB_BW*COLS-1:0]   o_acc_bias,
`ifdef ACC_SAT_EN
    output logic [CNT_BW-1:0]       o_beat_cnt,
    output logic                    o_acc_sat
`else
    output logic [CNT_BW-1:0]       o_beat_cnt
`endif
);

    typedef enum logic [1:0] {S_FIRST, S_ACCUM, S_OUT} state_t;

    state_t                   state;
    logic signed [BI_BW-1:0]  bias    [COLS];
    logic signed [AB_BW-1:0]  acc     [COLS];
    logic signed [AB_BW-1:0]  acc_nxt [COLS];
    logic                     accept;
`ifdef ACC_SAT_EN
    logic                     any_clamp;
`endif

    // Ready is forced low during reset so no beat is taken while the tile is being abandoned.
    assign o_ps_ready = ~rst && (state != S_OUT);
    assign accept     = i_ps_valid && o_ps_ready;

    always_comb begin
        logic signed [AB_BW-1:0] ps_x;
        logic signed [AB_BW-1:0] base;
`ifdef ACC_SAT_EN
        logic [AB_BW:0]          sum;
        any_clamp = 1'b0;
`else
        logic [AB_BW-1:0]        sum;
`endif
        for (int i = 0; i < COLS; i++) begin
            ps_x = AB_BW'($signed(i_ps_data[(i+1)*PS_BW-1 -: PS_BW]));
            base = (state == S_FIRST) ? AB_BW'(bias[i]) : acc[i];
`ifdef ACC_SAT_EN
            sum  = {base[AB_BW-1], base} + {ps_x[AB_BW-1], ps_x};
            if (sum[AB_BW] != sum[AB_BW-1]) begin
                acc_nxt[i] = sum[AB_BW] ? {1'b1, {(AB_BW-1){1'b0}}} : {1'b0, {(AB_BW-1){1'b1}}};
                any_clamp  = 1'b1;
            end else begin
                acc_nxt[i] = sum[AB_BW-1:0];
            end
`else
            sum        = base + ps_x;
            acc_nxt[i] = sum;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FIRST;
            o_acc_valid <= 1'b0;
            o_beat_cnt  <= '0;
`ifdef ACC_SAT_EN
            o_acc_sat   <= 1'b0;
`endif
            for (int i = 0; i < COLS; i++) begin
                acc[i]  <= '0;
                bias[i] <= '0;
            end
        end else begin
            // The adders read the old bias, so a write never touches the tile it overlaps.
            if (i_bias_we) begin
                for (int i = 0; i < COLS; i++)
                    bias[i] <= i_bias_data[(i+1)*BI_BW-1 -: BI_BW];
            end
            case (state)
                S_FIRST: begin
                    if (accept) begin
                        for (int i = 0; i < COLS; i++) acc[i] <= acc_nxt[i];
                        o_beat_cnt <= CNT_BW'(1);
`ifdef ACC_SAT_EN
                        o_acc_sat  <= any_clamp;
`endif
                        if (i_ps_last) begin
                            state       <= S_OUT;
                            o_acc_valid <= 1'b1;
                        end else begin
                            state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        for (int i = 0; i < COLS; i++) acc[i] <= acc_nxt[i];
                        if (o_beat_cnt != {CNT_BW{1'b1}})
                            o_beat_cnt <= o_beat_cnt + 1'b1;
`ifdef ACC_SAT_EN
                        o_acc_sat  <= o_acc_sat | any_clamp;
`endif
                        if (i_ps_last) begin
                            state       <= S_OUT;
                            o_acc_valid <= 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (i_acc_ready) begin
                        state       <= S_FIRST;
                        o_acc_valid <= 1'b0;
                    end
                end
                default: state <= S_FIRST;
            endcase
        end
    end

    for (genvar g = 0; g < COLS; g++) begin : g_pack
        assign o_acc_bias[(g+1)*AB_BW-1 -: AB_BW] = acc[g];
    end

endmodule

// File: tb/tb_acc_bias_128.sv
// tb/tb_acc_bias_128.sv - scoreboard bench for acc_bias_128 with directed tiles
module tb_acc_bias_128;

    logic         clk;
    logic         rst;
    logic         i_bias_we;
    logic [79:0]  i_bias_data;
    logic         i_ps_valid;
    logic         i_ps_last;
    logic [79:0]  i_ps_data;
    logic         o_ps_ready;
    logic         o_acc_valid;
    logic         i_acc_ready;
    logic [124:0] o_acc_bias;
    logic [7:0]   o_beat_cnt;
`ifdef ACC_SAT_EN
    logic         o_acc_sat;
`endif

    acc_bias_128 dut (
        .clk         (clk),
        .rst         (rst),
        .i_bias_we   (i_bias_we),
        .i_bias_data (i_bias_data),
        .i_ps_valid  (i_ps_valid),
        .i_ps_last   (i_ps_last),
        .i_ps_data   (i_ps_data),
        .o_ps_ready  (o_ps_ready),
        .o_acc_valid (o_acc_valid),
        .i_acc_ready (i_acc_ready),
        .o_acc_bias  (o_acc_bias),
`ifdef ACC_SAT_EN
        .o_beat_cnt  (o_beat_cnt),
        .o_acc_sat   (o_acc_sat)
`else
        .o_beat_cnt  (o_beat_cnt)
`endif
    );

    typedef struct {
        logic [124:0] data;
        logic [7:0]   cnt;
        logic         sat;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [124:0] pk_ab(input int c4, input int c3, input int c2, input int c1, input int c0);
        int v[5];
        logic [124:0] r;
        v = '{c0, c1, c2, c3, c4};
        r = '0;
        for (int i = 0; i < 5; i++) r[i*25 +: 25] = 25'(v[i]);
        return r;
    endfunction

    function automatic logic [79:0] pk16(input int c4, input int c3, input int c2, input int c1, input int c0);
        int v[5];
        logic [79:0] r;
        v = '{c0, c1, c2, c3, c4};
        r = '0;
        for (int i = 0; i < 5; i++) r[i*16 +: 16] = 16'(v[i]);
        return r;
    endfunction

    task automatic push_exp(input logic [124:0] d, input logic [7:0] c, input logic s);
        exp_t e;
        e.data = d;
        e.cnt  = c;
        e.sat  = s;
        q.push_back(e);
    endtask

    // Called at #1 after a rising edge; returns at #1 after the edge that accepted the beat.
    task automatic send_beat(input logic [79:0] d, input logic last);
        bit took;
        took = 1'b0;
        i_ps_valid = 1'b1;
        i_ps_data  = d;
        i_ps_last  = last;
        for (int k = 0; k < 200 && !took; k++) begin
            @(negedge clk);
            took = o_ps_ready;
            @(posedge clk);
            #1;
        end
        if (!took) begin
            checks++;
            errors++;
            $display("FAIL beat_accept: got timeout expected acceptance");
        end
        i_ps_valid = 1'b0;
        i_ps_last  = 1'b0;
    endtask

    task automatic write_bias(input logic [79:0] d);
        i_bias_we   = 1'b1;
        i_bias_data = d;
        @(posedge clk);
        #1;
        i_bias_we   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (o_acc_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid with data %0h expected no result", o_acc_bias);
            end else begin
                chk("acc_bias", 128'(o_acc_bias), 128'(q[0].data));
                chk("beat_cnt", 128'(o_beat_cnt), 128'(q[0].cnt));
`ifdef ACC_SAT_EN
                chk("acc_sat", 128'(o_acc_sat), 128'(q[0].sat));
`endif
                chk("ps_ready_in_out", 128'(o_ps_ready), 128'(1'b0));
                if (i_acc_ready) q.delete(0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        i_bias_we = 1'b0;
        i_bias_data = '0;
        i_ps_valid = 1'b0;
        i_ps_last = 1'b0;
        i_ps_data = '0;
        i_acc_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 128'(o_acc_valid), 128'(1'b0));
        chk("rst_bias", 128'(o_acc_bias), 128'(0));
        chk("rst_cnt", 128'(o_beat_cnt), 128'(0));
        chk("rst_ready", 128'(o_ps_ready), 128'(1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 128'(o_ps_ready), 128'(1'b1));
        @(posedge clk);
        #1;

        // Three-beat tile over a mixed bias vector.
        write_bias(pk16(10, -5, 0, 3, 127));
        push_exp(pk_ab(16, 1, 6, 9, 133), 8'd3, 1'b0);
        send_beat(pk16(1, 1, 1, 1, 1), 1'b0);
        send_beat(pk16(2, 2, 2, 2, 2), 1'b0);
        send_beat(pk16(3, 3, 3, 3, 3), 1'b1);
        @(negedge clk);
        chk("latency_3beat", 128'(o_acc_valid), 128'(1'b1));
        idle(2);

        // Single-beat negative tile.
        write_bias(pk16(0, 0, 0, 0, 0));
        push_exp(pk_ab(-200, -200, -200, -200, -200), 8'd1, 1'b0);
        send_beat(pk16(-200, -200, -200, -200, -200), 1'b1);
        idle(2);

        // Backpressure with the next tile's beat pending upstream.
        i_acc_ready = 1'b0;
        push_exp(pk_ab(5, 4, 3, 2, 1), 8'd1, 1'b0);
        send_beat(pk16(5, 4, 3, 2, 1), 1'b1);
        push_exp(pk_ab(9, 9, 9, 9, 9), 8'd1, 1'b0);
        i_ps_valid = 1'b1;
        i_ps_data  = pk16(9, 9, 9, 9, 9);
        i_ps_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid_held", 128'(o_acc_valid), 128'(1'b1));
            @(posedge clk);
            #1;
        end
        i_acc_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("ready_after_hs", 128'(o_ps_ready), 128'(1'b1));
        @(posedge clk);
        #1;
        i_ps_valid = 1'b0;
        i_ps_last  = 1'b0;
        @(negedge clk);
        chk("new_tile_valid", 128'(o_acc_valid), 128'(1'b1));
        idle(2);

        // Bias write coinciding with a first beat takes effect on the following tile.
        write_bias(pk16(7, 7, 7, 7, 7));
        push_exp(pk_ab(8, 8, 8, 8, 8), 8'd1, 1'b0);
        i_bias_we   = 1'b1;
        i_bias_data = pk16(100, 100, 100, 100, 100);
        send_beat(pk16(1, 1, 1, 1, 1), 1'b1);
        i_bias_we   = 1'b0;
        idle(2);
        push_exp(pk_ab(101, 101, 101, 101, 101), 8'd1, 1'b0);
        send_beat(pk16(1, 1, 1, 1, 1), 1'b1);
        idle(2);

        // 600 beats of the maximum partial sum.
        write_bias(pk16(0, 0, 0, 0, 0));
`ifdef ACC_SAT_EN
        push_exp(pk_ab(16777215, 16777215, 16777215, 16777215, 16777215), 8'd255, 1'b1);
`else
        push_exp(pk_ab(-13894232, -13894232, -13894232, -13894232, -13894232), 8'd255, 1'b0);
`endif
        for (int b = 0; b < 600; b++)
            send_beat(pk16(32767, 32767, 32767, 32767, 32767), (b == 599) ? 1'b1 : 1'b0);
        idle(2);

        // Reset on the second beat of a four-beat tile.
        write_bias(pk16(50, 50, 50, 50, 50));
        send_beat(pk16(1, 1, 1, 1, 1), 1'b0);
        i_ps_valid = 1'b1;
        i_ps_data  = pk16(1, 1, 1, 1, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        i_ps_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_valid", 128'(o_acc_valid), 128'(1'b0));
        chk("midrst_bias", 128'(o_acc_bias), 128'(0));
        chk("midrst_cnt", 128'(o_beat_cnt), 128'(0));
        chk("midrst_ready", 128'(o_ps_ready), 128'(1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        push_exp(pk_ab(4, 4, 4, 4, 4), 8'd1, 1'b0);
        send_beat(pk16(4, 4, 4, 4, 4), 1'b1);
        idle(4);

        chk("queue_drained", 128'(q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
